// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target: address match, write pulses, stretched reads
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       rw_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Events stay masked until the presets have been flushed out of the
  // synchronizer and edge registers, so a reset taken mid-transfer cannot
  // fabricate a START from stale preset values.
  localparam logic [3:0] SETTLE = 4'(SYNC_STAGES + 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [3:0]             settle_q, settle_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [6:0]             tx_shift_q, tx_shift_d;
  logic                   scl_o_q, scl_o_d;
  logic                   sda_o_q, sda_o_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   start_q, start_d;
  logic                   stop_q, stop_d;
  logic                   rw_q, rw_d;
  logic                   busy_q, busy_d;

  logic scl_s, sda_s, armed;
  logic start_ev, stop_ev, scl_rise, scl_fall;
  logic do_load;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign armed    = (settle_q == SETTLE);
  assign start_ev = armed & scl_prev_q & scl_s & sda_prev_q & ~sda_s;
  assign stop_ev  = armed & scl_prev_q & scl_s & ~sda_prev_q & sda_s;
  assign scl_rise = armed & ~scl_prev_q & scl_s;
  assign scl_fall = armed & scl_prev_q & ~scl_s;

  assign scl_o      = scl_o_q;
  assign sda_o      = sda_o_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = tx_ready_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign rw_o       = rw_q;
  assign busy_o     = busy_q;

  // Next-state logic: bus-event decode, protocol FSM and read-byte loading
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    settle_d   = armed ? settle_q : settle_q + 4'd1;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    scl_o_d    = scl_o_q;
    sda_o_d    = sda_o_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    do_load    = 1'b0;

    if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      start_d   = 1'b1;
      sda_o_d   = 1'b1;
      scl_o_d   = 1'b1;
      busy_d    = 1'b0;
    end else if (stop_ev) begin
      state_d = IDLE;
      stop_d  = 1'b1;
      sda_o_d = 1'b1;
      scl_o_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              rw_d    = shift_q[0];
              busy_d  = 1'b1;
              sda_o_d = 1'b0;
              state_d = ADDR_ACK;
            end else begin
              sda_o_d = 1'b1;
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_o_d   = 1'b1;
            bit_cnt_d = 4'd0;
            if (rw_q) do_load = 1'b1;
            else      state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_o_d    = 1'b0;
            state_d    = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_o_d   = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end
        end
        RD_LOAD: do_load = 1'b1;
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_o_d   = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = RD_ACK;
            end else begin
              sda_o_d    = tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          // bit_cnt 9 marks "master acknowledged, fetch next byte on the fall"
          if (scl_rise) begin
            if (sda_s) begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end else begin
              bit_cnt_d = 4'd9;
            end
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            do_load = 1'b1;
          end
        end
        IGNORE: begin
          sda_o_d = 1'b1;
          scl_o_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // SCL is low here; either put bit 7 out now or stretch until data arrives
    if (do_load) begin
      if (tx_valid_i) begin
        tx_shift_d = tx_data_i[6:0];
        tx_ready_d = 1'b1;
        sda_o_d    = tx_data_i[7];
        scl_o_d    = 1'b1;
        bit_cnt_d  = 4'd1;
        state_d    = RD_DATA;
      end else begin
        sda_o_d = 1'b1;
        scl_o_d = 1'b0;
        state_d = RD_LOAD;
      end
    end
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      settle_q   <= 4'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      tx_shift_q <= 7'd0;
      scl_o_q    <= 1'b1;
      sda_o_q    <= 1'b1;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      settle_q   <= settle_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      scl_o_q    <= scl_o_d;
      sda_o_q    <= sda_o_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

endmodule
